// File: rtl/and_bist_pkg.sv
// Shared types and helpers for the AND-gate BIST loop.
// Build option: AND_BIST_EXHAUSTIVE_EN selects the exhaustive 2-bit up-counter
// pattern source (4 patterns) instead of the 2-bit LFSR (3 patterns).
package and_bist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StCompare, StDone} state_e;

`ifdef AND_BIST_EXHAUSTIVE_EN
  localparam int unsigned NUM_PATTERNS = 4;
`else
  localparam int unsigned NUM_PATTERNS = 3;
`endif

  // Fault-free AND with a zero MISR seed compacts to this in both modes.
  localparam logic [2:0] GOLDEN_SIG = 3'b001;

  // Pattern LFSR over p = {a,b}: 01 -> 10 -> 11 -> 01; 00 is a lock-up state.
  function automatic logic [1:0] lfsr_next(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

  // 3-bit MISR, s = {s2,s1,s0}: s0' = s2^in, s1' = s0^s2, s2' = s1.
  function automatic logic [2:0] misr_next(input logic [2:0] s, input logic in);
    return {s[1], s[0] ^ s[2], s[2] ^ in};
  endfunction

endpackage

// File: rtl/and_bist_misr.sv
// Response-compaction MISR for single-output CUT BIST blocks.
// load has priority over en; reset returns the register to RST_VAL.
module and_bist_misr
  import and_bist_pkg::*;
#(
  parameter int unsigned      SIG_W   = 3,
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] seed,
  input  logic             in,
  output logic [SIG_W-1:0] sig
);

  // Signature register: seed on load, compact one response bit per enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= misr_next(sig, in);
    end
  end

endmodule

// File: rtl/and_bist_tpg_ctrl.sv
// Pattern generation / response compaction controller for the AND-gate BIST loop.
// Drives cut_a/cut_b, compacts cut_y into a MISR, pulses compare for the
// downstream comparator and latches its result as bist_fail.
// Build option: AND_BIST_EXHAUSTIVE_EN -> binary up-counter patterns 00..11
// (LFSR_SEED unused); otherwise a 2-bit LFSR seeded with LFSR_SEED.
module and_bist_tpg_ctrl
  import and_bist_pkg::*;
#(
  parameter int unsigned      SIG_W     = 3,
  parameter logic [1:0]       LFSR_SEED = 2'b01,
  parameter logic [SIG_W-1:0] MISR_SEED = '0,
  parameter int unsigned      CMP_PULSE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             cut_a,
  output logic             cut_b,
  input  logic             cut_y,
  output logic [SIG_W-1:0] signature,
  output logic             compare,
  input  logic             result,
  output logic             busy,
  output logic             done,
  output logic             bist_fail
);

  localparam int unsigned CNT_W  = $clog2(NUM_PATTERNS + 1);
  localparam int unsigned PCNT_W = $clog2(CMP_PULSE + 1);

  state_e            state_q;
  logic [1:0]        pat_q;
  logic [1:0]        pat_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              accept;
  logic              run;

`ifdef AND_BIST_EXHAUSTIVE_EN
  localparam logic [1:0] PAT_INIT = 2'b00;
  assign pat_nxt = pat_q + 2'd1;
`else
  localparam logic [1:0] PAT_INIT = LFSR_SEED;
  assign pat_nxt = lfsr_next(pat_q);
`endif

  // start only counts from IDLE or DONE; while busy it has no effect.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign run    = (state_q == StRun);
  assign cut_a  = pat_q[1];
  assign cut_b  = pat_q[0];

  and_bist_misr #(
    .SIG_W  (SIG_W),
    .RST_VAL(MISR_SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .en  (run),
    .seed(MISR_SEED),
    .in  (cut_y),
    .sig (signature)
  );

  // Test sequencer FSM with registered status and compare outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= 2'b00;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      compare   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bist_fail <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            pat_q     <= PAT_INIT;
            cnt_q     <= '0;
            bist_fail <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          pat_q <= pat_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_PATTERNS - 1)) begin
            pat_q   <= 2'b00;
            pcnt_q  <= '0;
            compare <= 1'b1;
            state_q <= StCompare;
          end
        end
        StCompare: begin
          pcnt_q <= pcnt_q + 1'b1;
          if (pcnt_q == PCNT_W'(CMP_PULSE - 1)) begin
            bist_fail <= result;
            compare   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_and_bist_tpg_ctrl.sv
// Directed bench for and_bist_tpg_ctrl: CUT model with injectable faults,
// comparator model, and a scoreboard of expected signature / pass-fail.
module tb_and_bist_tpg_ctrl;

  localparam logic [2:0] GOLDEN    = 3'b001;
  localparam int         CMP_PULSE = 2;
`ifdef AND_BIST_EXHAUSTIVE_EN
  localparam int NP = 4;
`else
  localparam int NP = 3;
`endif

  // CUT fault modes
  localparam int F_NONE = 0;
  localparam int F_Y1   = 1;
  localparam int F_A1   = 2;
  localparam int F_Y0   = 3;
  localparam int F_B1   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       result = 1'b0;
  logic       cut_a, cut_b, cut_y, compare, busy, done, bist_fail;
  logic [2:0] signature;
  int         fault_mode = F_NONE;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_pat [4];

  typedef struct {
    logic [2:0] sig;
    logic       fail;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  and_bist_tpg_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cut_a    (cut_a),
    .cut_b    (cut_b),
    .cut_y    (cut_y),
    .signature(signature),
    .compare  (compare),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .bist_fail(bist_fail)
  );

  // CUT: 2-input AND with optional stuck-at faults
  assign cut_y = (fault_mode == F_Y1) ? 1'b1 :
                 (fault_mode == F_Y0) ? 1'b0 :
                 (((fault_mode == F_A1) ? 1'b1 : cut_a) & ((fault_mode == F_B1) ? 1'b1 : cut_b));

  // Downstream comparator: samples signature on compare rising edge
  always @(posedge compare) begin
    #1;
    result = (signature !== GOLDEN);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test; poke pulses start during RUN and COMPARE.
  task automatic do_run(input int fault, input logic [2:0] exp_sig, input bit poke);
    int   lat;
    int   cmp_hi;
    exp_t e;
    fault_mode = fault;
    sb_q.push_back('{sig: exp_sig, fail: (exp_sig !== GOLDEN)});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    cmp_hi = 0;
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_done", 8'(done), 8'd0);
    chk("start_fail_clr", 8'(bist_fail), 8'd0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("pattern%0d", i), 8'({cut_a, cut_b}), 8'(exp_pat[i]));
      if (poke && i == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk("cmp_entry", 8'(compare), 8'd1);
    chk("cmp_entry_sig", 8'(signature), 8'(exp_sig));
    chk("cmp_cut_idle", 8'({cut_a, cut_b}), 8'd0);
    while (!done && lat < 20) begin
      if (compare) cmp_hi++;
      if (poke) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk("latency", 8'(lat), 8'(NP + CMP_PULSE));
    chk("cmp_width", 8'(cmp_hi), 8'(CMP_PULSE));
    chk("done_busy", 8'(busy), 8'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("signature", 8'(signature), 8'(e.sig));
      chk("bist_fail", 8'(bist_fail), 8'(e.fail));
    end
    @(posedge clk);
    #1;
    chk("done_hold", 8'({done, compare, signature}), 8'({1'b1, 1'b0, exp_sig}));
  endtask

  // Start a test, advance n edges, then assert reset asynchronously.
  task automatic reset_mid(input int n);
    fault_mode = F_NONE;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 8'(busy), 8'd1);
    chk("pre_rst_cmp", 8'(compare), 8'((n >= NP) ? 1 : 0));
    rst = 1'b1;
    #1;
    chk("rst_ctrl", 8'({compare, busy, done, bist_fail}), 8'd0);
    chk("rst_sig", 8'(signature), 8'd0);
    chk("rst_cut", 8'({cut_a, cut_b}), 8'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef AND_BIST_EXHAUSTIVE_EN
    exp_pat[0] = 2'b00; exp_pat[1] = 2'b01; exp_pat[2] = 2'b10; exp_pat[3] = 2'b11;
`else
    exp_pat[0] = 2'b01; exp_pat[1] = 2'b10; exp_pat[2] = 2'b11; exp_pat[3] = 2'b00;
`endif
    #1;
    chk("reset_ctrl", 8'({compare, busy, done, bist_fail}), 8'd0);
    chk("reset_sig", 8'(signature), 8'd0);
    chk("reset_cut", 8'({cut_a, cut_b}), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_start", 8'({busy, done}), 8'd0);

    reset_mid(2);
    do_run(F_NONE, 3'b001, 1'b0);
    reset_mid(NP);
    do_run(F_NONE, 3'b001, 1'b0);
`ifdef AND_BIST_EXHAUSTIVE_EN
    do_run(F_B1, 3'b011, 1'b0);
    do_run(F_Y1, 3'b100, 1'b0);
`else
    do_run(F_Y1, 3'b111, 1'b0);
    do_run(F_A1, 3'b101, 1'b0);
`endif
    do_run(F_Y0, 3'b000, 1'b0);
    // restart from DONE after a failing run, with start poked while busy
    do_run(F_NONE, 3'b001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
